// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - shared Hamming(7,4) types, constants and encode function
package hamming74_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CODE_LEN  = 7;
    localparam int FRAME_LEN = 8;

    localparam int POS_D0 = 0;
    localparam int POS_D1 = 1;
    localparam int POS_D2 = 2;
    localparam int POS_P0 = 3;
    localparam int POS_D3 = 4;
    localparam int POS_P1 = 5;
    localparam int POS_P2 = 6;

    localparam logic [2:0] LAST_IDX = 3'(CODE_LEN - 1);

    // Parity placement makes every decoder syndrome zero for a clean codeword.
    function automatic logic [6:0] hamming74_encode(input logic [3:0] nibble);
        logic [6:0] cw;
        cw         = '0;
        cw[POS_D0] = nibble[0];
        cw[POS_D1] = nibble[1];
        cw[POS_D2] = nibble[2];
        cw[POS_D3] = nibble[3];
        cw[POS_P0] = nibble[2] ^ nibble[1] ^ nibble[0];
        cw[POS_P1] = nibble[3] ^ nibble[1] ^ nibble[0];
        cw[POS_P2] = nibble[3] ^ nibble[2] ^ nibble[0];
        return cw;
    endfunction

endpackage

// File: rtl/hamming74_codeword_gen.sv
// rtl/hamming74_codeword_gen.sv - combinational nibble to 7-bit codeword
module hamming74_codeword_gen
    import hamming74_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_codeword
);

    assign o_codeword = hamming74_encode(i_nibble);

endmodule

// File: rtl/tt_um_hamming_encoder_74.sv
// rtl/tt_um_hamming_encoder_74.sv - serial Hamming(7,4) encoder, 7 code bits plus 1 gap per frame
module tt_um_hamming_encoder_74
    import hamming74_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       encode_out,
    output logic       frame_sync,
    output logic       busy
);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [6:0] r_shift;
    logic       r_out;
    logic       r_sync;
    logic       r_busy;
    logic [6:0] w_codeword;
    logic       w_accept;

    hamming74_codeword_gen u_codeword_gen (
        .i_nibble   (data_in),
        .o_codeword (w_codeword)
    );

    assign data_ready = ena && (r_state == ST_IDLE || r_state == ST_GAP);
    assign w_accept   = data_valid && data_ready;

    // Outputs are registered one edge behind the state, so busy rises with c0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_out   <= IDLE_LEVEL;
            r_sync  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    r_out  <= IDLE_LEVEL;
                    r_sync <= 1'b0;
                    r_busy <= 1'b0;
                end
                ST_SEND: begin
                    r_out   <= r_shift[0];
                    r_shift <= {1'b0, r_shift[6:1]};
                    r_sync  <= (r_idx == 3'd0);
                    r_busy  <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_GAP;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_GAP: begin
                    r_out   <= IDLE_LEVEL;
                    r_sync  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
            if (w_accept) begin
                r_state <= ST_SEND;
                r_idx   <= '0;
                r_shift <= w_codeword;
            end
        end
    end

    assign encode_out = r_out;
    assign frame_sync = r_sync;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tt_um_hamming_encoder_74.sv
// tb/tb_tt_um_hamming_encoder_74.sv - scoreboard bench for the serial Hamming(7,4) encoder
module tb_tt_um_hamming_encoder_74;

    localparam logic IDLE = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       encode_out;
    logic       frame_sync;
    logic       busy;

    tt_um_hamming_encoder_74 #(.IDLE_LEVEL(IDLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .encode_out (encode_out),
        .frame_sync (frame_sync),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] cw;
        int         c0_edge;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   en_edges = 0;
    logic last_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: data bits at 0,1,2,4; each parity is the even parity of a data subset.
    function automatic logic [6:0] model(input logic [3:0] d);
        int v;
        v = d[0] * 1 + d[1] * 2 + d[2] * 4 + d[3] * 16;
        v += ($countones(d & 4'b0111) % 2) * 8;
        v += ($countones(d & 4'b1011) % 2) * 32;
        v += ($countones(d & 4'b1101) % 2) * 64;
        return 7'(v);
    endfunction

    always @(posedge clk) begin
        last_en <= ena && rst_n;
        if (ena && rst_n) en_edges <= en_edges + 1;
    end

    logic       collecting = 1'b0;
    logic       gap_pending = 1'b0;
    int         cnt = 0;
    logic [6:0] got = '0;
    exp_t       cur;
    logic       prev_out = IDLE;
    logic       prev_sync = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting  = 1'b0;
            gap_pending = 1'b0;
            cnt         = 0;
            sbq.delete();
            prev_out    = IDLE;
            prev_sync   = 1'b0;
        end else begin
            if (last_en) begin
                if (frame_sync) begin
                    if (collecting || sbq.size() == 0) begin
                        check("unexpected_sync", 32'd1, 32'd0);
                    end else begin
                        cur = sbq.pop_front();
                        check("c0_timing", en_edges, cur.c0_edge);
                        check("busy_c0", busy, 1'b1);
                        got         = '0;
                        got[0]      = encode_out;
                        cnt         = 1;
                        collecting  = 1'b1;
                        gap_pending = 1'b0;
                    end
                end else if (collecting) begin
                    got[cnt[2:0]] = encode_out;
                    cnt++;
                    check("busy_send", busy, 1'b1);
                    if (cnt == 7) begin
                        check("codeword", got, cur.cw);
                        collecting  = 1'b0;
                        gap_pending = 1'b1;
                    end
                end else if (gap_pending) begin
                    check("gap_level", encode_out, IDLE);
                    check("gap_busy", busy, 1'b1);
                    gap_pending = 1'b0;
                end else begin
                    check("idle_level", encode_out, IDLE);
                    check("idle_busy", busy, 1'b0);
                end
            end else begin
                check("hold_out", encode_out, prev_out);
                check("hold_sync", frame_sync, prev_sync);
            end
            check("data_ready", data_ready, ena && sbq.size() == 0 && !collecting);
            prev_out  = encode_out;
            prev_sync = frame_sync;
        end
    end

    // Inputs change 1 time unit after the edge; acceptance is judged just before the next edge.
    task automatic cycle(input logic e, input logic v, input logic [3:0] d,
                         input logic [6:0] cw_exp, output logic acc);
        exp_t item;
        ena        = e;
        data_valid = v;
        data_in    = d;
        @(negedge clk);
        acc = e && v && data_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            item.cw      = cw_exp;
            item.c0_edge = en_edges + 1;
            sbq.push_back(item);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [6:0] cw_exp, output int acc_edge);
        logic acc;
        acc = 1'b0;
        acc_edge = -1;
        for (int i = 0; i < 20 && !acc; i++) begin
            cycle(1'b1, 1'b1, d, cw_exp, acc);
        end
        if (acc) acc_edge = en_edges;
        else check("send_timeout", 32'd0, 32'd1);
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0, 7'd0, acc);
    endtask

    initial begin
        int   e0;
        int   e1;
        logic acc;
        logic [3:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", encode_out, IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_sync", frame_sync, 1'b0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        check("ready_after_reset", data_ready, 1'b1);
        @(posedge clk);
        #1;

        send(4'hB, 7'h33, e0); idle(10);
        send(4'h1, 7'h69, e0); idle(10);
        send(4'hF, 7'h7F, e0); idle(10);
        send(4'h0, 7'h00, e0); idle(10);

        send(4'h5, 7'h25, e0);
        send(4'hA, 7'h5A, e1);
        check("b2b_period", e1 - e0, 8);
        idle(10);

        send(4'hB, 7'h33, e0);
        idle(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h7, 7'd0, acc);
        check("freeze_c3", encode_out, 1'b0);
        idle(10);

        send(4'hF, 7'h7F, e0);
        idle(3);
        rst_n = 1'b0;
        #1;
        check("midrst_out", encode_out, IDLE);
        check("midrst_busy", busy, 1'b0);
        check("midrst_sync", frame_sync, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'h6, model(4'h6), e0);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            d = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, d, model(d), acc);
        end

        for (int i = 0; i < 40 && (sbq.size() != 0 || collecting || gap_pending); i++) idle(1);
        if (sbq.size() != 0 || collecting || gap_pending) check("drain_timeout", 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_hamming_encoder_74.md
# tt_um_hamming_encoder_74

Serial Hamming(7,4) encoder and transmitter: the sending end of the single-wire Hamming(7,4) link whose far end is `tt_um_hamming_decoder_74`. It accepts a 4-bit nibble over a valid/ready handshake and computes the 7-bit codeword. It shifts the codeword out LSB-first, one bit per enabled cycle, followed by one gap cycle. The 8-cycle frame matches the decoder's 7-bit-collect + 1-cycle-decode cadence.

## Interface
- `IDLE_LEVEL`, default 1'b0: level driven on `encode_out` while idle, during the gap slot, and out of reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  global enable; low freezes all state and outputs.
- `data_in`  in  4  nibble to encode, d3..d0.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can accept a nibble this cycle (combinational).
- `encode_out`  out  1  serial codeword bit (registered).
- `frame_sync`  out  1  high while `encode_out` carries codeword bit 0 (registered).
- `busy`  out  1  high in SEND or GAP.

## Operation
- **Codeword bit positions** (c6..c0), chosen so the decoder's syndromes are all zero:
  - Data bits: c0=d0, c1=d1, c2=d2, c4=d3.
  - c3 = d2^d1^d0.
  - c5 = d3^d1^d0.
  - c6 = d3^d2^d0.
- **Handshake**:
  - Accept occurs when `ena && data_valid && data_ready`.
  - `data_ready = ena && (state==IDLE || state==GAP)`.
  - The codeword is latched into a 7-bit shift register on accept.
  - `data_in` is ignored at all other times.
- **FSM states**:
  - IDLE: `encode_out`=IDLE_LEVEL. On accept, go to SEND with bit index 0.
  - SEND: drive c[index], increment index. Leaving index 6 goes to GAP.
  - GAP: `encode_out`=IDLE_LEVEL for one cycle. Accept here goes directly to SEND index 0, giving back-to-back frames of exactly 8 cycles. Otherwise go to IDLE.
- **Bit index** is 3 bits and counts 0..6. It never reaches 7 in SEND; value 7 is unused.
- **`ena` low**:
  - State, index, shift register and all registered outputs hold.
  - `data_ready`=0.
  - A frame resumes where it stopped when `ena` returns.
- **Asynchronous reset**, any time including mid-frame:
  - State → IDLE, index=0, shift register=0.
  - `encode_out`=IDLE_LEVEL, `frame_sync`=0, `busy`=0.
  - The frame in flight is discarded; nothing resumes after reset.
- `data_valid` held high continuously produces a nibble every 8 enabled cycles with no IDLE cycle between frames.

## Timing
- Accept at enabled edge t → c0 on `encode_out` after edge t+1, with `frame_sync`=1 for that cycle only.
- c6 appears after edge t+7, the gap after edge t+8.
- A new accept during the gap cycle puts the next c0 out after edge t+9.
- Latency from accept to last codeword bit: 7 enabled cycles. Frame period: 8 enabled cycles.
- `busy` is registered with the state and rises together with c0.
- `data_ready` depends on state and `ena` only, never on `data_valid`. There is no combinational path from `data_valid` to `data_ready`.

## Structure
- Package `hamming74_pkg`:
  - State enum (IDLE, SEND, GAP).
  - Codeword bit-position constants: data positions 0,1,2,4; parity positions 3,5,6.
  - `FRAME_LEN`=8 and `CODE_LEN`=7.
  - Pure function `hamming74_encode(nibble) → [6:0]`, shared with decoder checks.
- One combinational sub-module, `hamming74_codeword_gen`: 4-bit in, 7-bit out, wraps the package function.
- The FSM, index counter and shift register live in the top.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → `encode_out`=IDLE_LEVEL, `busy`=0, `frame_sync`=0 immediately. After release `data_ready`=1 with `ena`=1; the next accept starts a clean frame.
- **Encoding values** (serial order c0..c6):
  - `data_in`=0xB → 1,1,0,0,1,1,0 (codeword 0x33), then one IDLE_LEVEL gap bit.
  - 0x1 → 1,0,0,1,0,1,1 (0x69).
  - 0xF → all 1s (0x7F).
  - 0x0 → all 0s.
- **Back-to-back:** `data_valid` held high with 0x5 then 0xA → frames exactly 8 cycles apart. `frame_sync` pulses every 8 cycles; `data_ready` is high only in IDLE or GAP.
- **Enable freeze:** `ena` low for 3 cycles at bit index 3 → `encode_out` holds c3 and `data_ready`=0. The remaining bits follow unchanged after `ena` returns.
- **Loopback:** connect to `tt_um_hamming_decoder_74` → `decode_out`=`data_in` for all 16 nibbles.
- **Loopback with error:** same setup, one codeword bit flipped in flight → decoder output matches its single-bit-correction result.
